// File: rtl/wall_collision_tracker.sv
// Wall tile store with sequential head-vs-wall collision scan.
// Spawns during a scan are parked in a one-entry pending slot.
module wall_collision_tracker #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             btnrst,
    input  logic             wall_spawn,
    input  logic [10:0]      newwall_x,
    input  logic [10:0]      newwall_y,
    input  logic             head_valid,
    input  logic [10:0]      snakehead_x,
    input  logic [10:0]      snakehead_y,
    output logic             busy,
    output logic             check_done,
    output logic             collision,
    output logic [IDX_W:0]   wall_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]    count_q, count_d;
    logic [IDX_W:0]    n_q, n_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [10:0]       hx_q, hx_d, hy_q, hy_d;
    logic              coll_q, coll_d;
    logic              pend_q, pend_d;
    logic [10:0]       px_q, px_d, py_q, py_d;
    logic [21:0]       mem_q [DEPTH];

    logic              commit, direct;
    logic [IDX_W-1:0]  wa_direct;
    logic [IDX_W+1:0]  sum;
    logic [21:0]       entry;

    // Pending entry is written first so it stays older than a same-edge spawn.
    assign commit    = (state_q == DONE) && pend_q;
    assign direct    = wall_spawn && (state_q != SCAN);
    assign wa_direct = wr_ptr_q + IDX_W'(commit);
    assign sum       = {1'b0, count_q} + (IDX_W+2)'(commit) + (IDX_W+2)'(direct);
    assign entry     = mem_q[idx_q];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        hx_d     = hx_q;
        hy_d     = hy_q;
        coll_d   = coll_q;
        pend_d   = pend_q;
        px_d     = px_q;
        py_d     = py_q;
        wr_ptr_d = wr_ptr_q + IDX_W'(commit) + IDX_W'(direct);
        count_d  = (sum > (IDX_W+2)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : sum[IDX_W:0];
        if (state_q == SCAN && wall_spawn) begin
            pend_d = 1'b1;
            px_d   = newwall_x;
            py_d   = newwall_y;
        end
        case (state_q)
            IDLE: begin
                if (head_valid) begin
                    hx_d  = snakehead_x;
                    hy_d  = snakehead_y;
                    n_d   = count_q;
                    idx_d = '0;
                    if (count_q == '0) begin
                        coll_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (entry == {hx_q, hy_q}) begin
                    coll_d  = 1'b1;
                    state_d = DONE;
                end else if ({1'b0, idx_q} == n_q - 1'b1) begin
                    coll_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge btnrst) begin
        if (btnrst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            hx_q     <= '0;
            hy_q     <= '0;
            coll_q   <= 1'b0;
            pend_q   <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            hx_q     <= hx_d;
            hy_q     <= hy_d;
            coll_q   <= coll_d;
            pend_q   <= pend_d;
            px_q     <= px_d;
            py_q     <= py_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!btnrst) begin
            if (commit)
                mem_q[wr_ptr_q] <= {px_q, py_q};
            if (direct)
                mem_q[wa_direct] <= {newwall_x, newwall_y};
        end
    end

    assign busy       = (state_q == SCAN);
    assign check_done = (state_q == DONE);
    assign collision  = coll_q;
    assign wall_count = count_q;

endmodule
